spi_frame_controller: RTL and testbench
=======================================

// Module: spi_frame_controller
// PURPOSE
// - Sequences SPI byte reception into validated RGBW parameter frames: header hunt, payload capture, XOR checksum check, inter-byte timeout.
// - Holds a validated frame in a shadow bank and commits it to the colour/PWM datapath only on a PWM period boundary, so outputs never change mid-period.
// - Sits between the SPI receiver (buff_rx_spi/rdy) and the colour generator/PWM; it supersedes direct per-byte dispatch.
// PARAMETERS
// - TIMEOUT_CYCLES  4096  max clk cycles between byte strobes inside a frame; 16-bit counter
// - COMMIT_SYNC     1     1: commit on pwm_period_end; 0: commit on the cycle after validation
// PORTS
// - clk             in   1  system clock; single clock domain
// - reset           in   1  asynchronous, active-low reset
// - buff_rx_spi     in   8  last received SPI byte; stable while rdy high
// - rdy             in   1  byte-ready from SPI receiver; asynchronous to clk
// - pwm_period_end  in   1  1-cycle pulse, last cycle of PWM period
// - lint_out, colorIdx_out, red_out, green_out, blue_out, white_out, mode_out  out 8 each  committed frame fields
// - frame_ok        out  1  1-cycle pulse, checksum passed
// - frame_err       out  1  1-cycle pulse, frame aborted
// - err_code        out  2  01 timeout, 10 checksum; held until next frame_err or frame_ok (cleared to 00)
// - busy            out  1  high when state != HUNT or commit pending
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs, shadow, staging, counters = 0; state HUNT; pending = 0.
// - rdy passes a 2-FF synchroniser + rising-edge detect -> strobe; byte is sampled on the 3rd rising clk edge after rdy rises. Levels are not re-counted; one rdy pulse = one byte.
// - Frame: 0x55, lint, colorIdx, red, green, blue, white, mode, chk; chk = XOR of the 7 payload bytes (header excluded).
// - FSM:
//   - HUNT: strobe && byte==0x55 -> PAYLOAD, idx=0, acc=0; any other byte is ignored with no error.
//   - PAYLOAD: each strobe stores byte to staging[idx], acc^=byte, idx++; after idx 6 -> CHECK.
//   - CHECK: strobe: if byte==acc -> staging copied to shadow, pending=1, frame_ok pulse, err_code=00. Otherwise frame_err with err_code=10. Both cases -> HUNT.
// - Timeout: counter clears on every strobe and counts in PAYLOAD/CHECK. At TIMEOUT_CYCLES -> frame_err, err_code=01, HUNT, staging discarded. No timeout in HUNT.
// - Commit: pending && pwm_period_end (or COMMIT_SYNC=0) -> all 7 outputs load shadow in one cycle; pending=0.
//   - Validation and pwm_period_end in the same cycle: outputs load the new frame directly and pending stays 0.
//   - A second valid frame before commit overwrites the shadow; latest wins.
// - Failed or timed-out frames never touch shadow or outputs. A pending commit survives a later failed frame.
// - Strobe and timeout expiry in the same cycle: the strobe wins and the counter clears.
// - A 0x55 inside PAYLOAD/CHECK is data, not resync.
// - Reset mid-frame or mid-pending: everything clears and the outputs go to 0 immediately.
// STRUCTURE
// - Shared include rgbw_pkg.vh holds: FRAME_HEADER=8'h55, PAYLOAD_LEN=7, state encodings (HUNT/PAYLOAD/CHECK), ERR_TIMEOUT=2'b01, ERR_CHECKSUM=2'b10.
// - One sub-module: rdy_sync_edge (2-FF sync + rising-edge pulse, async active-low reset).
// - The top holds the FSM, staging[7], shadow[7], output registers, timeout counter and checksum accumulator.
// TESTING
// - Reset: assert reset mid-PAYLOAD with outputs nonzero -> all outputs/busy/err_code 0 without waiting for a clock edge; next good frame is accepted.
// - Good frame 55,10,20,30,40,50,60,01,chk=71 -> frame_ok; outputs stay old until pwm_period_end, then lint=10 ... mode=01.
// - Bad checksum (same frame, chk=70) -> frame_err, err_code=10, outputs unchanged, busy drops.
// - Timeout: 55,10,20 then idle TIMEOUT_CYCLES -> frame_err, err_code=01. Next 55 frame is accepted from idx 0.
// - Two good frames (red=AA, then red=BB) before one pwm_period_end -> red_out=BB; validation coincident with pwm_period_end -> immediate commit.
// - Header hunt: bytes 00,FF,55,... -> garbage ignored, no frame_err; frame with 0x55 as payload byte is captured as data.

Source files
------------

// File: rtl/spi_frame_controller_pkg.sv
// Shared constants and types for the SPI RGBW frame controller.
package spi_frame_controller_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'h55;
  localparam int         PAYLOAD_LEN  = 7;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  // Byte 0 is lint, byte 6 is mode.
  typedef logic [PAYLOAD_LEN-1:0][7:0] frame_t;

endpackage

// File: rtl/spi_frame_controller_rdy_sync_edge.sv
// Brings the asynchronous rdy strobe into the clk domain and turns each
// rising edge into a single-cycle pulse.
module spi_frame_controller_rdy_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic rdy,
  output logic strobe
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // Shift rdy through the two synchroniser stages and keep the last level.
  always_comb begin
    sync_d = {sync_q[0], rdy};
    prev_d = sync_q[1];
  end

  // Synchroniser and edge-history flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign strobe = sync_q[1] & ~prev_q;

endmodule

// File: rtl/spi_frame_controller.sv
// Assembles SPI bytes into checksummed RGBW frames and commits validated
// frames to the output registers on a PWM period boundary.
module spi_frame_controller
  import spi_frame_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit COMMIT_SYNC    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] buff_rx_spi,
  input  logic       rdy,
  input  logic       pwm_period_end,
  output logic [7:0] lint_out,
  output logic [7:0] colorIdx_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out,
  output logic [7:0] white_out,
  output logic [7:0] mode_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST = 3'(PAYLOAD_LEN - 1);

  logic strobe;

  spi_frame_controller_rdy_sync_edge u_rdy_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rdy),
    .strobe (strobe)
  );

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] tmo_q, tmo_d;
  frame_t      staging_q, staging_d;
  frame_t      shadow_q, shadow_d;
  frame_t      out_q, out_d;
  logic        pending_q, pending_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        commit_now;

  assign commit_now = COMMIT_SYNC ? pwm_period_end : 1'b1;

  // Frame sequencing, checksum, timeout and commit decisions.
  always_comb begin
    // NOTE: every _d starts from its _q (pulses from 0) so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    staging_d   = staging_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    pending_d   = pending_q;
    err_code_d  = err_code_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;

    // The idle counter only runs inside a frame; a byte always restarts it.
    tmo_d = (state_q == ST_HUNT || strobe) ? '0 : tmo_q + 16'd1;

    if (pending_q && commit_now) begin
      out_d     = shadow_q;
      pending_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        if (strobe && buff_rx_spi == FRAME_HEADER) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_PAYLOAD, ST_CHECK: begin
        if (strobe) begin
          if (state_q == ST_PAYLOAD) begin
            staging_d[idx_q] = buff_rx_spi;
            acc_d            = acc_q ^ buff_rx_spi;
            idx_d            = idx_q + 3'd1;
            if (idx_q == IDX_LAST) state_d = ST_CHECK;
          end else begin
            state_d = ST_HUNT;
            if (buff_rx_spi == acc_q) begin
              shadow_d   = staging_q;
              frame_ok_d = 1'b1;
              err_code_d = ERR_NONE;
              // A frame validated on the boundary itself goes straight out.
              if (COMMIT_SYNC && pwm_period_end) begin
                out_d     = staging_q;
                pending_d = 1'b0;
              end else begin
                pending_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHECKSUM;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_HUNT;
          staging_d   = '0;
          tmo_d       = '0;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      acc_q       <= '0;
      tmo_q       <= '0;
      // NOTE: staging/shadow are small flop arrays, not RAM, so they clear with reset.
      staging_q   <= '0;
      shadow_q    <= '0;
      out_q       <= '0;
      pending_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      pending_q   <= pending_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign lint_out     = out_q[0];
  assign colorIdx_out = out_q[1];
  assign red_out      = out_q[2];
  assign green_out    = out_q[3];
  assign blue_out     = out_q[4];
  assign white_out    = out_q[5];
  assign mode_out     = out_q[6];
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q != ST_HUNT) || pending_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Self-checking bench for spi_frame_controller: directed scenarios plus
// randomized frames against a queue-based frame model.
module tb_spi_frame_controller;

  localparam int TIMEOUT = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buff_rx_spi;
  logic       rdy;
  logic       pwm_period_end;
  logic [7:0] lint_out, colorIdx_out, red_out, green_out, blue_out, white_out, mode_out;
  logic       frame_ok, frame_err, busy;
  logic [1:0] err_code;
  logic [55:0] out_bus;

  int checks = 0;
  int errors = 0;

  // Reference model: frame contents as a byte queue, outputs as 56-bit words.
  bit          m_in_frame;
  logic [7:0]  m_buf[$];
  logic [55:0] m_out, m_shadow;
  bit          m_pending;
  logic [1:0]  m_err;

  spi_frame_controller #(.TIMEOUT_CYCLES(TIMEOUT), .COMMIT_SYNC(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .buff_rx_spi    (buff_rx_spi),
    .rdy            (rdy),
    .pwm_period_end (pwm_period_end),
    .lint_out       (lint_out),
    .colorIdx_out   (colorIdx_out),
    .red_out        (red_out),
    .green_out      (green_out),
    .blue_out       (blue_out),
    .white_out      (white_out),
    .mode_out       (mode_out),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .err_code       (err_code),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  assign out_bus = {lint_out, colorIdx_out, red_out, green_out, blue_out, white_out, mode_out};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_buf.delete();
    m_out      = '0;
    m_shadow   = '0;
    m_pending  = 1'b0;
    m_err      = 2'b00;
  endtask

  function automatic logic [55:0] pack_buf();
    logic [55:0] w = '0;
    for (int i = 0; i < 7; i++) w[8*(6-i) +: 8] = m_buf[i];
    return w;
  endfunction

  // One received byte; 'on_boundary' means a PWM period ends as it is taken.
  task automatic model_byte(input logic [7:0] b, input bit on_boundary,
                            output int e_ok, output int e_err);
    logic [7:0] x = 8'h00;
    e_ok  = 0;
    e_err = 0;
    if (on_boundary && m_pending) begin
      m_out     = m_shadow;
      m_pending = 1'b0;
    end
    if (!m_in_frame) begin
      if (b == 8'h55) begin
        m_in_frame = 1'b1;
        m_buf.delete();
      end
    end else if (m_buf.size() < 7) begin
      m_buf.push_back(b);
    end else begin
      foreach (m_buf[i]) x ^= m_buf[i];
      m_in_frame = 1'b0;
      if (b == x) begin
        e_ok     = 1;
        m_shadow = pack_buf();
        m_err    = 2'b00;
        if (on_boundary) m_out = m_shadow;
        else             m_pending = 1'b1;
      end else begin
        e_err = 1;
        m_err = 2'b10;
      end
    end
  endtask

  // Present one byte with an rdy pulse and count the result pulses seen.
  task automatic send_byte(input logic [7:0] b, input bit on_boundary);
    int ok_n = 0, err_n = 0, e_ok, e_err;
    @(negedge clk);
    buff_rx_spi = b;
    rdy         = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) pwm_period_end = on_boundary;
      if (i == 3) pwm_period_end = 1'b0;
      if (i == 4) rdy = 1'b0;
      if (frame_ok)  ok_n++;
      if (frame_err) err_n++;
    end
    model_byte(b, on_boundary, e_ok, e_err);
    check("frame_ok_pulses", 64'(ok_n), 64'(e_ok));
    check("frame_err_pulses", 64'(err_n), 64'(e_err));
  endtask

  task automatic send_frame(input logic [55:0] p, input logic [7:0] corrupt, input bit boundary_on_chk);
    logic [7:0] x = 8'h00;
    send_byte(8'h55, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send_byte(p[8*(6-i) +: 8], 1'b0);
      x ^= p[8*(6-i) +: 8];
    end
    send_byte(x ^ corrupt, boundary_on_chk);
  endtask

  task automatic pwm_pulse();
    @(negedge clk);
    pwm_period_end = 1'b1;
    @(negedge clk);
    pwm_period_end = 1'b0;
    if (m_pending) begin
      m_out     = m_shadow;
      m_pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_outs"}, 64'(out_bus), 64'(m_out));
    check({tag, "_err_code"}, 64'(err_code), 64'(m_err));
    check({tag, "_busy"}, 64'(busy), 64'(m_in_frame || m_pending));
  endtask

  initial begin
    int waited;
    bit seen;
    logic [55:0] p;
    logic [7:0]  c;

    reset = 1'b0; rdy = 1'b0; buff_rx_spi = 8'h00; pwm_period_end = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame: held in shadow until the period boundary.
    send_frame(56'h10_20_30_40_50_60_01, 8'h00, 1'b0);
    check_state("good_before_pwm");
    pwm_pulse();
    check_state("good_after_pwm");
    check("good_red", 64'(red_out), 64'h30);

    // Same frame with a bad checksum: error, outputs untouched.
    send_frame(56'h10_20_30_40_50_60_01, 8'h01, 1'b0);
    check_state("bad_chk");

    // Garbage before a header is ignored; 0x55 inside a frame is data.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(56'h55_01_02_03_04_05_55, 8'h00, 1'b0);
    check_state("hunt_data55");
    pwm_pulse();
    check_state("hunt_commit");

    // Two good frames before one boundary: the latest wins.
    send_frame(56'h01_02_AA_03_04_05_06, 8'h00, 1'b0);
    send_frame(56'h01_02_BB_03_04_05_06, 8'h00, 1'b0);
    pwm_pulse();
    check_state("latest_wins");
    check("latest_red", 64'(red_out), 64'hBB);

    // Validation on the boundary itself commits at once.
    send_frame(56'h11_22_33_44_55_66_77, 8'h00, 1'b1);
    check_state("coincident");

    // Timeout partway through a frame.
    send_byte(8'h55, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < TIMEOUT + 64) begin
      @(negedge clk);
      waited++;
      if (frame_err) seen = 1'b1;
    end
    check("tmo_seen", 64'(seen), 64'd1);
    check("tmo_window", 64'(waited >= TIMEOUT - 16 && waited <= TIMEOUT + 16), 64'd1);
    m_in_frame = 1'b0;
    m_err      = 2'b01;
    check_state("timeout");
    send_frame(56'h0A_0B_0C_0D_0E_0F_10, 8'h00, 1'b0);
    check_state("after_timeout");
    pwm_pulse();
    check_state("after_timeout_commit");

    // Randomized frames: garbage, corrupted checksums, random boundaries.
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(3) == 0) begin
        c = 8'($urandom_range(255));
        if (c == 8'h55) c = 8'h54;
        send_byte(c, 1'b0);
      end
      p = {$urandom(), 24'($urandom())};
      c = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(p, c, $urandom_range(4) == 0);
      if ($urandom_range(1) == 0) pwm_pulse();
      check_state("random");
    end

    // Make sure outputs are nonzero, then reset in the middle of a payload.
    send_frame(56'hC1_C2_C3_C4_C5_C6_C7, 8'h00, 1'b1);
    check_state("pre_reset");
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(56'h21_22_23_24_25_26_27, 8'h00, 1'b0);
    check_state("post_reset");
    pwm_pulse();
    check_state("post_reset_commit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
